statistic: RTL and testbench
============================

Name: statistic

Overview:
- Performance/statistics and syscall-service block for the 5-stage MIPS CPU.
- Counts elapsed cycles, unconditional jumps, conditional branches and taken conditional branches, each qualified by retire/event strobes from the pipeline.
- Services the syscall instruction:
  - latches the $a0 value for display;
  - raises a sticky halt on the exit service code ($v0 == 10) or on an external strong halt.
- Once halted, all state freezes until reset.

Parameters:
- CNT_W, 32, width of every counter output and of A/B/SyscallOut.
- HALT_CODE, 10, value of A ($v0) that makes a syscall terminate the program.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- A  in  CNT_W  syscall service number ($v0 register value).
- B  in  CNT_W  syscall argument ($a0 register value).
- syscall_t  in  1  a syscall instruction is executing this cycle.
- condi_suc  in  1  the conditional branch this cycle is taken; meaningful only with branch_t.
- un_branch_t  in  1  an unconditional jump (j/jal/jr) executes this cycle.
- branch_t  in  1  a conditional branch executes this cycle.
- strong_halt  in  1  external force-halt request.
- total_cycles  out  CNT_W  number of non-halted clock cycles since reset.
- uncondi_num  out  CNT_W  unconditional jump count.
- condi_num  out  CNT_W  conditional branch count.
- condi_suc_num  out  CNT_W  taken conditional branch count.
- SyscallOut  out  CNT_W  last displayed syscall argument.
- halt  out  1  sticky halt flag to the CPU.

Behaviour:
- Reset (rst=1 at rising edge): all counters, SyscallOut and halt go to 0. Reset overrides every other input, including while halted.
- All outputs are registered; each output reflects inputs sampled at the previous rising edge (1-cycle latency).
- Active cycle (halt==0, rst==0), evaluated in parallel at each edge:
  - total_cycles += 1 unconditionally.
  - uncondi_num += 1 if un_branch_t.
  - condi_num += 1 if branch_t.
  - condi_suc_num += 1 if branch_t && condi_suc. condi_suc without branch_t is ignored.
  - Syscall with A != HALT_CODE: SyscallOut <= B. Otherwise SyscallOut holds.
  - Syscall with A == HALT_CODE: halt <= 1; SyscallOut holds.
  - strong_halt == 1: halt <= 1, regardless of syscall_t/A.
- Simultaneous events: all increments and the halt set apply in the same edge.
  - The cycle that sets halt is itself counted.
  - Example: a non-exit syscall plus strong_halt both latches B and halts.
- Halted (halt==1): every register holds its value; all event inputs are ignored; halt stays 1 until rst.
- Arithmetic: unsigned CNT_W-bit. Counters wrap modulo 2^CNT_W (all-ones + 1 -> 0) unless STAT_SAT_EN is defined.
- Invariant: condi_suc_num <= condi_num at all times (without wrap).

Optional Feature:
- Macro STAT_SAT_EN.
- Defined: every counter saturates at all-ones and holds there instead of wrapping; other behaviour unchanged.
- Undefined: counters wrap to 0.

Test Plan:
- Reset then idle:
  - stimulus: rst=1 for 5 edges, then rst=0 with all strobes 0 for 7 edges.
  - response: all counters 0 during reset; afterwards total_cycles=7, other counters 0, SyscallOut=0, halt=0.
- Branch counting: over 10 active cycles, drive 3 cycles of un_branch_t, 4 cycles of branch_t (2 of them with condi_suc=1), plus 2 cycles of condi_suc=1 with branch_t=0.
  - response: uncondi_num=3, condi_num=4, condi_suc_num=2, total_cycles=10.
- Print syscall: syscall_t=1, A=1, B=123 for one cycle.
  - response: SyscallOut=123 next cycle, halt=0.
  - Then A=34, B=0xDEADBEEF -> SyscallOut=0xDEADBEEF.
- Exit syscall: syscall_t=1, A=10, B=55.
  - response: halt=1 next cycle, SyscallOut unchanged.
  - Further strobes and cycles leave every output frozen; rst=1 clears everything to 0.
- All-ones stimulus after reset: A=0, B=123, with syscall_t, condi_suc, un_branch_t, branch_t and strong_halt all 1.
  - response after first edge: total_cycles=1, uncondi_num=1, condi_num=1, condi_suc_num=1, SyscallOut=123, halt=1.
  - Outputs frozen at those values thereafter.
- Wrap/saturate: preload by running with CNT_W=4 for 16 active cycles.
  - response: total_cycles=0 without STAT_SAT_EN; 15 (held) with STAT_SAT_EN.

Source files
------------

// File: rtl/statistic.sv
// Cycle/branch statistics and syscall service for the 5-stage MIPS core.
// Optional build macro STAT_SAT_EN makes every counter saturate instead of wrapping.
module statistic #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned HALT_CODE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] A,
  input  logic [CNT_W-1:0] B,
  input  logic             syscall_t,
  input  logic             condi_suc,
  input  logic             un_branch_t,
  input  logic             branch_t,
  input  logic             strong_halt,
  output logic [CNT_W-1:0] total_cycles,
  output logic [CNT_W-1:0] uncondi_num,
  output logic [CNT_W-1:0] condi_num,
  output logic [CNT_W-1:0] condi_suc_num,
  output logic [CNT_W-1:0] SyscallOut,
  output logic             halt
);

  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] uncondi_q, uncondi_d;
  logic [CNT_W-1:0] condi_q, condi_d;
  logic [CNT_W-1:0] condi_suc_q, condi_suc_d;
  logic [CNT_W-1:0] sys_out_q, sys_out_d;
  logic             halt_q, halt_d;
  logic             exit_call;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
`ifdef STAT_SAT_EN
    if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
`else
    if (en) return v + 1'b1;
    return v;
`endif
  endfunction

  assign exit_call = syscall_t && (A == CNT_W'(HALT_CODE));

  always_comb begin
    total_d     = total_q;
    uncondi_d   = uncondi_q;
    condi_d     = condi_q;
    condi_suc_d = condi_suc_q;
    sys_out_d   = sys_out_q;
    halt_d      = halt_q;
    // Once halted everything freezes until reset.
    if (!halt_q) begin
      total_d     = bump(total_q, 1'b1);
      uncondi_d   = bump(uncondi_q, un_branch_t);
      condi_d     = bump(condi_q, branch_t);
      condi_suc_d = bump(condi_suc_q, branch_t && condi_suc);
      if (syscall_t && !exit_call) sys_out_d = B;
      if (exit_call || strong_halt) halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q     <= '0;
      uncondi_q   <= '0;
      condi_q     <= '0;
      condi_suc_q <= '0;
      sys_out_q   <= '0;
      halt_q      <= 1'b0;
    end else begin
      total_q     <= total_d;
      uncondi_q   <= uncondi_d;
      condi_q     <= condi_d;
      condi_suc_q <= condi_suc_d;
      sys_out_q   <= sys_out_d;
      halt_q      <= halt_d;
    end
  end

  assign total_cycles  = total_q;
  assign uncondi_num   = uncondi_q;
  assign condi_num     = condi_q;
  assign condi_suc_num = condi_suc_q;
  assign SyscallOut    = sys_out_q;
  assign halt          = halt_q;

endmodule

// File: tb/tb_statistic.sv
// Bench for statistic: directed vector table, randomized run against a reference model,
// and a narrow-counter instance for wrap/saturate.
module tb_statistic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic        syscall_t = 0, condi_suc = 0, un_branch_t = 0, branch_t = 0, strong_halt = 0;
  logic [31:0] total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut;
  logic        halt;

  statistic #(.CNT_W(32), .HALT_CODE(10)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .syscall_t(syscall_t), .condi_suc(condi_suc),
    .un_branch_t(un_branch_t), .branch_t(branch_t), .strong_halt(strong_halt),
    .total_cycles(total_cycles), .uncondi_num(uncondi_num), .condi_num(condi_num),
    .condi_suc_num(condi_suc_num), .SyscallOut(SyscallOut), .halt(halt)
  );

  // Narrow instance for the wrap/saturate check.
  logic       s_rst = 1'b1, s_ub = 1'b0;
  logic [3:0] s_tot, s_un, s_cn, s_csn, s_so;
  logic       s_halt;

  statistic #(.CNT_W(4), .HALT_CODE(10)) dut_small (
    .clk(clk), .rst(s_rst), .A(4'd0), .B(4'd0), .syscall_t(1'b0), .condi_suc(1'b0),
    .un_branch_t(s_ub), .branch_t(1'b0), .strong_halt(1'b0),
    .total_cycles(s_tot), .uncondi_num(s_un), .condi_num(s_cn),
    .condi_suc_num(s_csn), .SyscallOut(s_so), .halt(s_halt)
  );

  int n_checks = 0;
  int n_err = 0;

  // Reference model state.
  logic [31:0] m_tot, m_un, m_cn, m_csn, m_so;
  logic        m_halt;

  typedef struct {
    logic        r;
    logic [31:0] a, b;
    logic        sys, cs, ub, br, sh;
    logic [31:0] tot, un, cn, csn, so;
    logic        h;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic r, input logic [31:0] a, input logic [31:0] b,
                              input logic sys, input logic cs, input logic ub, input logic br,
                              input logic sh, input logic [31:0] tot, input logic [31:0] un,
                              input logic [31:0] cn, input logic [31:0] csn,
                              input logic [31:0] so, input logic h);
    vec_t v;
    v.r = r; v.a = a; v.b = b; v.sys = sys; v.cs = cs; v.ub = ub; v.br = br; v.sh = sh;
    v.tot = tot; v.un = un; v.cn = cn; v.csn = csn; v.so = so; v.h = h;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_tot = 0; m_un = 0; m_cn = 0; m_csn = 0; m_so = 0; m_halt = 0;
    end else if (!m_halt) begin
      m_tot = m_tot + 1;
      if (un_branch_t) m_un = m_un + 1;
      if (branch_t) m_cn = m_cn + 1;
      if (branch_t && condi_suc) m_csn = m_csn + 1;
      if (syscall_t && A != 32'd10) m_so = B;
      if ((syscall_t && A == 32'd10) || strong_halt) m_halt = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] tot, input logic [31:0] un,
                           input logic [31:0] cn, input logic [31:0] csn,
                           input logic [31:0] so, input logic h);
    check({tag, " total_cycles"}, total_cycles, tot);
    check({tag, " uncondi_num"}, uncondi_num, un);
    check({tag, " condi_num"}, condi_num, cn);
    check({tag, " condi_suc_num"}, condi_suc_num, csn);
    check({tag, " SyscallOut"}, SyscallOut, so);
    check({tag, " halt"}, {31'd0, halt}, {31'd0, h});
  endtask

  logic [3:0] wrap_exp;

  initial begin
    // Reset then idle.
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 0, 0, 0, 0, 0, 0, 0, i, 0, 0, 0, 0, 0);
    // Branch counting over 10 active cycles.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 2, 2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 3, 3, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 4, 3, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 5, 3, 2, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 6, 3, 3, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 7, 3, 4, 2, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 8, 3, 4, 2, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 9, 3, 4, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 10, 3, 4, 2, 0, 0);
    // Print syscalls, then exit syscall, then frozen.
    add(0, 1, 123, 1, 0, 0, 0, 0, 11, 3, 4, 2, 123, 0);
    add(0, 34, 32'hDEADBEEF, 1, 0, 0, 0, 0, 12, 3, 4, 2, 32'hDEADBEEF, 0);
    add(0, 10, 55, 1, 0, 0, 0, 0, 13, 3, 4, 2, 32'hDEADBEEF, 1);
    add(0, 1, 9, 1, 1, 1, 1, 1, 13, 3, 4, 2, 32'hDEADBEEF, 1);
    add(0, 1, 9, 1, 1, 1, 1, 0, 13, 3, 4, 2, 32'hDEADBEEF, 1);
    add(1, 1, 9, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    // Everything at once: counted, latched and halted in the same edge.
    add(0, 0, 123, 1, 1, 1, 1, 1, 1, 1, 1, 1, 123, 1);
    add(0, 0, 77, 1, 1, 1, 1, 1, 1, 1, 1, 1, 123, 1);
    add(0, 0, 77, 0, 0, 0, 0, 0, 1, 1, 1, 1, 123, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].r; A = vecs[i].a; B = vecs[i].b; syscall_t = vecs[i].sys;
      condi_suc = vecs[i].cs; un_branch_t = vecs[i].ub; branch_t = vecs[i].br;
      strong_halt = vecs[i].sh;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].tot, vecs[i].un, vecs[i].cn, vecs[i].csn,
                vecs[i].so, vecs[i].h);
    end

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      A = ($urandom_range(0, 5) == 0) ? 32'd10 : 32'($urandom_range(0, 40));
      B = $urandom;
      syscall_t = ($urandom_range(0, 7) == 0);
      condi_suc = 1'($urandom_range(0, 1));
      un_branch_t = 1'($urandom_range(0, 1));
      branch_t = 1'($urandom_range(0, 1));
      strong_halt = ($urandom_range(0, 199) == 0);
      step();
      check_all($sformatf("rnd%0d", i), m_tot, m_un, m_cn, m_csn, m_so, m_halt);
    end
    rst = 1'b0; syscall_t = 0; condi_suc = 0; un_branch_t = 0; branch_t = 0; strong_halt = 0;

    // Narrow counters: 16 active cycles wrap to 0, or hold at 15 when saturating.
    s_rst = 1'b1;
    @(posedge clk); #1;
    check("small reset total", {28'd0, s_tot}, 32'd0);
    s_rst = 1'b0; s_ub = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    check("small total at 15", {28'd0, s_tot}, 32'd15);
    check("small uncondi at 15", {28'd0, s_un}, 32'd15);
    @(posedge clk); #1;
`ifdef STAT_SAT_EN
    wrap_exp = 4'hF;
`else
    wrap_exp = 4'h0;
`endif
    check("small total after 16", {28'd0, s_tot}, {28'd0, wrap_exp});
    check("small uncondi after 16", {28'd0, s_un}, {28'd0, wrap_exp});
    check("small condi untouched", {28'd0, s_cn}, 32'd0);
    check("small halt", {31'd0, s_halt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
